// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;
  localparam int NREQ   = 2;

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder cell built from a chain of full adders.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/nibble_serial_add_arb.sv
// Two-requester round-robin front end feeding a shared 4-bit adder that is
// stepped LSB-nibble first over WIDTH/4 cycles with a registered carry.
module nibble_serial_add_arb
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co,
  output logic             res_id,
  output logic             busy
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  state_t            state, state_n;
  logic              prio;      // requester favoured on a tie
  logic              grant;     // requester selected this cycle
  logic [WIDTH-1:0]  a_sr, b_sr;
  logic              cy;
  logic [KW-1:0]     k;
  logic [NIBBLE-1:0] nib_s;
  logic              nib_co;
  logic [WIDTH+NIBBLE-1:0] sum_shift;

  rca4 u_rca4 (
    .a  (a_sr[NIBBLE-1:0]),
    .b  (b_sr[NIBBLE-1:0]),
    .ci (cy),
    .s  (nib_s),
    .co (nib_co)
  );

  // New nibble enters at the top; the whole result slides down one nibble.
  assign sum_shift = {nib_s, res_sum};

  // Arbitration, ready generation and next-state decode.
  always_comb begin
    state_n    = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = (req0_valid && req1_valid) ? prio : req1_valid;
    case (state)
      IDLE: begin
        req0_ready = rst_n && req0_valid && !grant;
        req1_ready = rst_n && req1_valid &&  grant;
        if (req0_ready || req1_ready) state_n = RUN;
      end
      RUN:     if (k == KLAST) state_n = DONE;
      DONE:    if (res_ready)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, operand/result shift registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      cy        <= 1'b0;
      k         <= '0;
      res_sum   <= '0;
      res_co    <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      res_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
      case (state)
        IDLE: if (state_n == RUN) begin
          a_sr   <= grant ? req1_a  : req0_a;
          b_sr   <= grant ? req1_b  : req0_b;
          cy     <= grant ? req1_ci : req0_ci;
          res_id <= grant;
          k      <= '0;
        end
        RUN: begin
          a_sr    <= a_sr >> NIBBLE;
          b_sr    <= b_sr >> NIBBLE;
          cy      <= nib_co;
          k       <= k + 1'b1;
          res_sum <= sum_shift[WIDTH+NIBBLE-1:NIBBLE];
          if (k == KLAST) res_co <= nib_co;
        end
        DONE: if (res_ready) prio <= ~res_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_arb.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural model.
module tb_nibble_serial_add_arb;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ci, req1_ci;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_co, res_id, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  nibble_serial_add_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_co(res_co), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d: timed out", nm, cyc);
  endtask

  // Behavioural model: one op in flight, result due N+1 cycles after the
  // accepting cycle, tie broken toward the requester not served last.
  bit           m_busy = 1'b0;
  bit           m_prio = 1'b0;
  int           m_done = 0;
  logic [W-1:0] m_sum;
  logic         m_co, m_id;

  always @(negedge clk) begin
    logic e0, e1, g, ev;
    logic [W:0] t;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_prio = 1'b0;
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      chk("rst_flags", {res_valid, busy, res_co, res_id}, 0);
      chk("rst_sum", res_sum, 0);
    end else begin
      e0 = 1'b0; e1 = 1'b0; g = 1'b0;
      if (!m_busy) begin
        g  = (req0_valid && req1_valid) ? m_prio : req1_valid;
        e0 = req0_valid && !g;
        e1 = req1_valid && g;
      end
      ev = m_busy && (cyc >= m_done);
      chk("ready", {req1_ready, req0_ready}, {e1, e0});
      chk("busy", busy, m_busy);
      chk("res_valid", res_valid, ev);
      if (ev) chk("result", {res_id, res_co, res_sum}, {m_id, m_co, m_sum});
      if (e0 || e1) begin
        t = g ? ({1'b0, req1_a} + {1'b0, req1_b} + (W+1)'(req1_ci))
              : ({1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(req0_ci));
        {m_co, m_sum} = t;
        m_id   = g;
        m_busy = 1'b1;
        m_done = cyc + N + 1;
      end else if (ev && res_ready) begin
        m_busy = 1'b0;
        m_prio = !m_id;
      end
    end
  end

  // Wait for the given requester's accept; returns just after the accept edge.
  task automatic wait_acc(input bit id, output int acc_cyc);
    bit ok = 1'b0;
    acc_cyc = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; acc_cyc = cyc; end
    end
    if (!ok) timeout("accept");
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Wait for a result and check it against literal values.
  task automatic wait_res(input string nm, input logic [W-1:0] s, input logic co,
                          input logic id, output int res_cyc);
    bit ok = 1'b0;
    res_cyc = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; res_cyc = cyc; end
    end
    if (!ok) timeout(nm);
    else chk(nm, {res_id, res_co, res_sum}, {id, co, s});
  endtask

  task automatic drive(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ci = ci; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ci = ci; end
  endtask

  initial begin
    int ta, tr;
    bit hs0, hs1;
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ci = 1'b0;
    req1_a = '0; req1_b = '0; req1_ci = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req0_ready", req0_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op with latency check.
    drive(0, 16'h1234, 16'h4321, 1'b0);
    wait_acc(0, ta);
    wait_res("single", 16'h5555, 1'b0, 1'b0, tr);
    chk("latency", tr - ta, 5);
    @(posedge clk); #1;

    // Full carry ripple from requester 1.
    drive(1, 16'hFFFF, 16'h0000, 1'b1);
    wait_acc(1, ta);
    wait_res("ripple", 16'h0000, 1'b1, 1'b1, tr);
    @(posedge clk); #1;

    // Reset so contention starts from the post-reset pointer.
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
    drive(0, 16'h0001, 16'h0001, 1'b0);
    drive(1, 16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    chk("contend_first", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1; req0_valid = 1'b0;
    wait_res("contend_r0", 16'h0002, 1'b0, 1'b0, tr);
    wait_acc(1, ta);
    wait_res("contend_r1", 16'h0000, 1'b1, 1'b1, tr);
    @(posedge clk); #1;
    drive(0, 16'h0010, 16'h0020, 1'b0);
    drive(1, 16'h0100, 16'h0200, 1'b0);
    @(negedge clk);
    chk("contend_third", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1; req0_valid = 1'b0;
    wait_res("third_r0", 16'h0030, 1'b0, 1'b0, tr);
    wait_acc(1, ta);
    wait_res("third_r1", 16'h0300, 1'b0, 1'b1, tr);
    @(posedge clk); #1;

    // Backpressure in DONE, with both requesters waiting.
    res_ready = 1'b0;
    drive(0, 16'h0F0F, 16'h0101, 1'b0);
    wait_acc(0, ta);
    wait_res("bp_first", 16'h1010, 1'b0, 1'b0, tr);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        drive(0, 16'h7000, 16'h9000, 1'b1);
        drive(1, 16'h0003, 16'h0004, 1'b0);
      end
      @(negedge clk);
      chk("bp_ready", {req1_ready, req0_ready}, 2'b00);
      chk("bp_hold", {res_valid, res_sum}, {1'b1, 16'h1010});
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", res_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle", {busy, req1_ready, req0_ready}, 3'b010);
    @(posedge clk); #1; req1_valid = 1'b0;
    wait_res("bp_r1", 16'h0007, 1'b0, 1'b1, tr);
    wait_acc(0, ta);
    wait_res("bp_r0", 16'h0001, 1'b1, 1'b0, tr);
    @(posedge clk); #1;

    // Reset in the middle of RUN abandons the op.
    drive(0, 16'hAAAA, 16'h5555, 1'b1);
    wait_acc(0, ta);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_res_after_rst", res_valid, 1'b0);
    end
    @(posedge clk); #1;
    drive(0, 16'h00FF, 16'h0001, 1'b0);
    wait_acc(0, ta);
    wait_res("post_rst", 16'h0100, 1'b0, 1'b0, tr);
    @(posedge clk); #1;

    // Randomized traffic; requesters hold valid and operands until accepted.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      res_ready = ($urandom_range(0, 3) != 0);
      if (hs0 || !req0_valid) begin
        req0_valid = $urandom_range(0, 1);
        req0_a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
        req0_b  = W'($urandom);
        req0_ci = $urandom_range(0, 1);
      end
      if (hs1 || !req1_valid) begin
        req1_valid = $urandom_range(0, 1);
        req1_a  = W'($urandom);
        req1_b  = ($urandom_range(0, 7) == 0) ? ~req1_a : W'($urandom);
        req1_ci = $urandom_range(0, 1);
      end
    end
    @(negedge clk);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    res_ready = 1'b1;
    // Unaccepted requests stay up until served, then drop.
    for (int i = 0; i < 60; i++) begin
      if (hs0) req0_valid = 1'b0;
      if (hs1) req1_valid = 1'b0;
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drained", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
